// File: rtl/sand_tile_store.sv
// sand_tile_store: double-buffered tile memory for a falling-sand grid.
// Two banks of TILE_DEPTH tiles, each tile TC cells of CELL_WIDTH bits.
// Tile and pixel reads use the active bank. Writes and zero-fill sweeps use
// the shadow bank. A swap exchanges the roles of the two banks.
//
// Ports
//   clk, rst_n                 clock; synchronous active-low reset
//   rd_req/rd_addr             tile read strobe/address (active bank)
//   rd_valid/rd_data           tile read result, one cycle after rd_req
//   wr_req/wr_addr/wr_data     tile write into the shadow bank
//   wr_err                     one-cycle pulse when a write was dropped
//   swap_req, clear_req        bank swap / shadow zero-fill requests
//   busy, active_bank          sweep or pending-swap status; bank being read
//   pix_valid/pix_x/pix_y      pixel lookup in cell coordinates
//   resolution                 grid width in cells
//   pix_data_valid/pix_data    pixel result, two cycles after pix_valid
module sand_tile_store #(
    parameter int CELL_WIDTH = 3,
    parameter int ROWS_TILE  = 4,
    parameter int COLS_TILE  = 4,
    parameter int TILE_DEPTH = 1024,
    localparam int AW  = $clog2(TILE_DEPTH),
    localparam int TC  = ROWS_TILE * COLS_TILE,
    localparam int TW  = TC * CELL_WIDTH,
    localparam int CIW = (TC > 1) ? $clog2(TC) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_req,
    input  logic [AW-1:0]         rd_addr,
    output logic                  rd_valid,
    output logic [TW-1:0]         rd_data,
    input  logic                  wr_req,
    input  logic [AW-1:0]         wr_addr,
    input  logic [TW-1:0]         wr_data,
    output logic                  wr_err,
    input  logic                  swap_req,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  active_bank,
    input  logic                  pix_valid,
    input  logic [9:0]            pix_x,
    input  logic [9:0]            pix_y,
    input  logic [9:0]            resolution,
    output logic                  pix_data_valid,
    output logic [CELL_WIDTH-1:0] pix_data
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLEAR     = 2'd1,
        ST_SWAP_WAIT = 2'd2
    } state_t;

    logic [TW-1:0] mem [0:1][0:TILE_DEPTH-1];

    state_t          state_r, state_s;
    logic            pend_r, pend_s;
    logic            active_s;
    logic [AW-1:0]   cnt_r, cnt_s;
    logic            mem_we_s;
    logic [AW-1:0]   mem_waddr_s;
    logic [TW-1:0]   mem_wdata_s;
    logic            wr_err_s;

    // Pixel path signals
    logic [31:0]     tile_s;
    logic [CIW-1:0]  cell_s;
    logic            in_range_s;
    logic            p1_valid_r;
    logic [AW-1:0]   p1_tile_r;
    logic [CIW-1:0]  p1_cell_r;
    logic            p1_in_r;
    logic            p1_bank_r;
    logic [TW-1:0]   sel_word_s;
    logic [CELL_WIDTH-1:0] sel_cell_s;

    // Next-state, bank control and shadow-write selection
    always_comb begin
        state_s     = state_r;
        pend_s      = pend_r;
        active_s    = active_bank;
        cnt_s       = cnt_r;
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_addr;
        mem_wdata_s = wr_data;
        wr_err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear_req) begin
                    // A write in the same cycle as clear_req would race the sweep; drop it.
                    state_s  = ST_CLEAR;
                    cnt_s    = {AW{1'b0}};
                    pend_s   = swap_req;
                    wr_err_s = wr_req;
                end else begin
                    // Write targets the pre-swap shadow even if swap_req is also set.
                    mem_we_s = wr_req;
                    if (swap_req) begin
                        active_s = ~active_bank;
                    end else begin
                        active_s = active_bank;
                    end
                end
            end
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = cnt_r;
                mem_wdata_s = {TW{1'b0}};
                wr_err_s    = wr_req;
                pend_s      = pend_r | swap_req;
                cnt_s       = cnt_r + AW'(1);
                if (cnt_r == AW'(TILE_DEPTH - 1)) begin
                    if (pend_r | swap_req) begin
                        state_s = ST_SWAP_WAIT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_SWAP_WAIT: begin
                active_s = ~active_bank;
                pend_s   = 1'b0;
                wr_err_s = wr_req;
                state_s  = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control registers and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pend_r      <= 1'b0;
            active_bank <= 1'b0;
            cnt_r       <= {AW{1'b0}};
            wr_err      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_s;
            pend_r      <= pend_s;
            active_bank <= active_s;
            cnt_r       <= cnt_s;
            wr_err      <= wr_err_s;
            busy        <= (state_s != ST_IDLE);
        end
    end

    // Shadow-bank storage write; contents are never reset
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_s) begin
            mem[~active_bank][mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Tile read port; data holds between reads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= {TW{1'b0}};
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= mem[active_bank][rd_addr];
            end else begin
                rd_data <= rd_data;
            end
        end
    end

    // Pixel address decode at 32-bit width so out-of-range tiles are not aliased
    always_comb begin
        tile_s     = (32'(pix_y) / 32'(ROWS_TILE)) * (32'(resolution) / 32'(COLS_TILE))
                   + (32'(pix_x) / 32'(COLS_TILE));
        cell_s     = CIW'((32'(pix_x) % 32'(COLS_TILE))
                   + (32'(pix_y) % 32'(ROWS_TILE)) * 32'(COLS_TILE));
        in_range_s = (tile_s < 32'(TILE_DEPTH)) && (pix_x < resolution);
    end

    // Pixel stage 1: capture decode and the bank active at this edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1_valid_r <= 1'b0;
            p1_tile_r  <= {AW{1'b0}};
            p1_cell_r  <= {CIW{1'b0}};
            p1_in_r    <= 1'b0;
            p1_bank_r  <= 1'b0;
        end else begin
            p1_valid_r <= pix_valid;
            p1_tile_r  <= AW'(tile_s);
            p1_cell_r  <= cell_s;
            p1_in_r    <= in_range_s;
            p1_bank_r  <= active_bank;
        end
    end

    // Cell select from the captured bank's tile word
    always_comb begin
        sel_word_s = mem[p1_bank_r][p1_tile_r];
        sel_cell_s = sel_word_s[32'(p1_cell_r) * CELL_WIDTH +: CELL_WIDTH];
    end

    // Pixel stage 2: output register, zero when out of range
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_data_valid <= 1'b0;
            pix_data       <= {CELL_WIDTH{1'b0}};
        end else begin
            pix_data_valid <= p1_valid_r;
            if (p1_valid_r) begin
                pix_data <= p1_in_r ? sel_cell_s : {CELL_WIDTH{1'b0}};
            end else begin
                pix_data <= pix_data;
            end
        end
    end

endmodule

// File: tb/tb_sand_tile_store.sv
// Testbench for sand_tile_store: directed vectors, scoreboard queues for the
// tile-read and pixel streams checked by an independent monitor, plus direct
// checks on status outputs. TILE_DEPTH is 64 so tile 33 exists for pixel tests.
module tb_sand_tile_store;

    localparam int TD = 64;
    localparam int AW = 6;
    localparam int TW = 48;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [TW-1:0] rd_data;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [TW-1:0] wr_data;
    logic          wr_err;
    logic          swap_req;
    logic          clear_req;
    logic          busy;
    logic          active_bank;
    logic          pix_valid;
    logic [9:0]    pix_x;
    logic [9:0]    pix_y;
    logic [9:0]    resolution;
    logic          pix_data_valid;
    logic [2:0]    pix_data;

    int checks = 0;
    int errors = 0;

    logic [TW-1:0] rd_q [$];
    logic [2:0]    pix_q [$];

    sand_tile_store #(
        .CELL_WIDTH(3), .ROWS_TILE(4), .COLS_TILE(4), .TILE_DEPTH(TD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
        .swap_req(swap_req), .clear_req(clear_req), .busy(busy), .active_bank(active_bank),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .resolution(resolution),
        .pix_data_valid(pix_data_valid), .pix_data(pix_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] fill(input logic [2:0] v);
        return {16{v}};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [TW-1:0] d);
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [TW-1:0] exp);
        rd_req = 1'b1; rd_addr = a;
        rd_q.push_back(exp);
        cyc();
        rd_req = 1'b0;
    endtask

    task automatic do_pix(input int x, input int y, input logic [2:0] exp);
        pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(y);
        pix_q.push_back(exp);
        cyc();
        pix_valid = 1'b0;
    endtask

    // Monitor: pops expected values whenever the DUT presents a result
    always @(negedge clk) begin
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected got %0h expected none", rd_data);
            end else begin
                chk("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
            end
        end
        if (pix_data_valid) begin
            if (pix_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL pix_unexpected got %0h expected none", pix_data);
            end else begin
                chk("pix_data", 64'(pix_data), 64'(pix_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0;
        wr_data = '0; swap_req = 1'b0; clear_req = 1'b0; pix_valid = 1'b0;
        pix_x = '0; pix_y = '0; resolution = 10'd128;
        repeat (2) cyc();
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_wr_err", 64'(wr_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_active", 64'(active_bank), 64'd0);
        chk("rst_pix_valid", 64'(pix_data_valid), 64'd0);
        chk("rst_pix_data", 64'(pix_data), 64'd0);
        rst_n = 1'b1;
        cyc();

        // Tile 3 := all 5s in shadow bank 0, swap, read back
        do_write(6'd3, fill(3'd5));
        swap_req = 1'b1; cyc(); swap_req = 1'b0;
        chk("swap_active", 64'(active_bank), 64'd1);
        chk("swap_busy", 64'(busy), 64'd0);
        do_read(6'd3, fill(3'd5));
        // Same-address read and write: read sees active bank's old content
        wr_req = 1'b1; wr_addr = 6'd3; wr_data = fill(3'd2);
        do_read(6'd3, fill(3'd5));
        wr_req = 1'b0;

        // Write coincident with swap lands in the pre-swap shadow (bank 0)
        wr_req = 1'b1; wr_addr = 6'd7; wr_data = fill(3'd6); swap_req = 1'b1;
        cyc();
        wr_req = 1'b0; swap_req = 1'b0;
        chk("swapwr_active", 64'(active_bank), 64'd0);
        do_read(6'd7, fill(3'd6));
        do_read(6'd3, fill(3'd2));

        // Clear + swap together, with a write dropped at the same edge
        clear_req = 1'b1; swap_req = 1'b1;
        wr_req = 1'b1; wr_addr = 6'd9; wr_data = fill(3'd7);
        cyc();
        clear_req = 1'b0; swap_req = 1'b0; wr_req = 1'b0;
        chk("clrwr_err", 64'(wr_err), 64'd1);
        chk("clr_busy", 64'(busy), 64'd1);
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 21) chk("clear_wr_err_pulse", 64'(wr_err), 64'd1);
            if (n == 22) chk("clear_wr_err_end", 64'(wr_err), 64'd0);
            if (n == 10) clear_req = 1'b1;
            if (n == 20) begin
                wr_req = 1'b1; wr_addr = 6'd2; wr_data = fill(3'd7);
            end
            cyc();
            clear_req = 1'b0; wr_req = 1'b0;
        end
        chk("busy_cycles", 64'(n), 64'(TD + 1));
        chk("clear_swap_active", 64'(active_bank), 64'd1);
        for (int i = 0; i < TD; i++) do_read(AW'(i), '0);

        // Pixel: tile 33 cell 9 := 3 in bank 0, swap to make it active
        do_write(6'd33, 48'(3) << 27);
        swap_req = 1'b1; cyc(); swap_req = 1'b0;
        chk("pix_swap_active", 64'(active_bank), 64'd0);
        do_pix(5, 6, 3'd3);
        do_pix(4, 6, 3'd0);
        do_pix(133, 2, 3'd0);   // x beyond resolution, would alias tile 33 cell 9
        do_pix(130, 6, 3'd0);
        do_pix(5, 14, 3'd0);    // tile 97 >= depth, low bits alias tile 33
        // Swap at the stage-2 edge: value must come from bank 0
        do_pix(5, 6, 3'd3);
        swap_req = 1'b1; cyc(); swap_req = 1'b0;
        chk("pix_swap2_active", 64'(active_bank), 64'd1);
        repeat (4) cyc();

        // Reset mid-clear aborts the sweep; next swap acts immediately
        clear_req = 1'b1; cyc(); clear_req = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_active", 64'(active_bank), 64'd0);
        swap_req = 1'b1; cyc(); swap_req = 1'b0;
        chk("postrst_swap", 64'(active_bank), 64'd1);
        chk("postrst_busy", 64'(busy), 64'd0);

        repeat (4) cyc();
        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
        chk("pix_q_empty", 64'(pix_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sand_tile_store.md
SAND_TILE_STORE -- requirements
Module: sand_tile_store

Interface
REQ-001 Param CELL_WIDTH, default 3, bits per sand cell.
REQ-002 Param ROWS_TILE, default 4, tile height in cells.
REQ-003 Param COLS_TILE, default 4, tile width in cells.
REQ-004 Param TILE_DEPTH, default 1024, tiles per bank (power of two); AW = clog2(TILE_DEPTH); TC = ROWS_TILE*COLS_TILE.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 rd_req  in  1  tile read strobe.
REQ-008 rd_addr  in  AW  tile read address.
REQ-009 rd_valid  out  1  tile read data valid.
REQ-010 rd_data  out  TC*CELL_WIDTH  tile read data; cell i at bits [i*CELL_WIDTH +: CELL_WIDTH].
REQ-011 wr_req  in  1  tile write strobe.
REQ-012 wr_addr  in  AW  tile write address.
REQ-013 wr_data  in  TC*CELL_WIDTH  tile write data, same packing as rd_data.
REQ-014 wr_err  out  1  one-cycle pulse: write dropped.
REQ-015 swap_req  in  1  request exchange of active/shadow bank.
REQ-016 clear_req  in  1  request zero-fill of shadow bank.
REQ-017 busy  out  1  clear sweep in progress or swap pending.
REQ-018 active_bank  out  1  index of bank currently read.
REQ-019 pix_valid  in  1  pixel lookup strobe.
REQ-020 pix_x, pix_y  in  10 each  cell coordinates.
REQ-021 resolution  in  10  grid width in cells (multiple of COLS_TILE).
REQ-022 pix_data_valid  out  1  pixel result valid.
REQ-023 pix_data  out  CELL_WIDTH  pixel cell value.

Function
REQ-024 Two banks of TILE_DEPTH x TC x CELL_WIDTH storage; tile and pixel reads use bank active_bank; writes and clears use bank ~active_bank (shadow).
REQ-025 Tile read: rd_req at cycle N -> rd_valid=1 and rd_data=active[rd_addr] at N+1; rd_valid=0 otherwise; rd_data holds its last value when rd_valid=0.
REQ-026 Tile write: wr_req with state IDLE writes wr_data to shadow[wr_addr] at that edge; readable from that bank after it becomes active.
REQ-027 Same-address rd_req and wr_req in one cycle: no conflict; read returns active bank's old content.
REQ-028 FSM states IDLE, CLEAR, SWAP_WAIT.
REQ-029 IDLE + clear_req -> CLEAR, counter=0; CLEAR writes zero to shadow[counter] each cycle, counter+1; exits after address TILE_DEPTH-1 (exactly TILE_DEPTH cycles).
REQ-030 CLEAR exit -> SWAP_WAIT if swap pending, else IDLE.
REQ-031 IDLE + swap_req (no clear_req) -> active_bank toggles at that edge; state stays IDLE; busy stays 0.
REQ-032 swap_req and clear_req together in IDLE: clear runs on current shadow, swap latched pending; swap_req during CLEAR also latches pending.
REQ-033 SWAP_WAIT: toggle active_bank, clear pending, -> IDLE next edge (one cycle).
REQ-034 busy=1 in CLEAR and SWAP_WAIT, else 0.
REQ-035 wr_req while state != IDLE, or wr_req coincident with clear_req in IDLE: write dropped, wr_err=1 next cycle.
REQ-036 clear_req during CLEAR or SWAP_WAIT ignored (no restart).
REQ-037 wr_req coincident with swap_req in IDLE: write lands in pre-swap shadow (i.e. becomes active after the swap).
REQ-038 Pixel path: tile = (pix_y/ROWS_TILE)*(resolution/COLS_TILE) + pix_x/COLS_TILE, cell = (pix_x%COLS_TILE) + (pix_y%ROWS_TILE)*COLS_TILE; computed at ≥AW+1-bit width before compare.
REQ-039 Pixel latency 2: pix_valid at N -> pix_data_valid=1 at N+2; stage 1 registers tile/cell/in-range, stage 2 selects cell from active-bank word.
REQ-040 tile >= TILE_DEPTH or pix_x >= resolution: pix_data=0 with pix_data_valid=1.
REQ-041 Swap between pixel stages: value taken from bank active at stage-1 edge.

Reset
REQ-042 rst_n=0 at a rising edge: state IDLE, active_bank=0, swap pending=0, counter=0, rd_valid=0, wr_err=0, busy=0, pix_data_valid=0, rd_data=0, pix_data=0.
REQ-043 Reset mid-CLEAR aborts sweep; partially cleared bank left as is; memory contents never reset.

Verification
REQ-044 Write 0x5 to all cells of tile 3, swap_req, rd_req addr 3 -> next cycle rd_valid=1, every cell=5.
REQ-045 clear_req+swap_req together, TILE_DEPTH=16 -> busy=1 for 17 cycles, active_bank toggles on 17th edge, all tiles of new active bank read 0.
REQ-046 wr_req during CLEAR -> wr_err pulse 1 cycle, target address still 0 after clear+swap.
REQ-047 resolution=128, pix (5,6) after tile 1*32+1=33 cell 9 written 0x3 and swapped -> pix_data=3 two cycles after pix_valid.
REQ-048 pix_x=130 with resolution=128 -> pix_data=0, pix_data_valid=1 at N+2.
REQ-049 rst_n=0 for one cycle mid-CLEAR -> busy=0, active_bank=0 next cycle; subsequent swap_req toggles without delay.
